// File: rtl/mult_c_collector.sv
// mult_c_collector
// Consumer end of the matrix multiplier result interface. Collects 2*N
// half-row words (N/2 elements each) into an N x N buffer C, then streams
// C out one element per beat on a valid/ready interface.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   start        one-cycle pulse, begins a new collection (IDLE only)
//   c_word       result word, element e at [BITS*(e+1)-1:BITS*e]
//   c_valid      c_word valid
//   c_ready      collector accepts c_word (high throughout COLLECT)
//   out_data     streamed element C[out_row][out_col]
//   out_row      row index of out_data
//   out_col      column index of out_data
//   out_valid    stream outputs valid (high throughout STREAM)
//   out_ready    downstream accepts the element
//   out_last     final element of the stream
//   c_matrix     flat buffer, C[r][c] at [BITS*(r*N+c+1)-1:BITS*(r*N+c)]
//   busy         high in COLLECT or STREAM
//   done         one-cycle pulse after the final stream handshake
//
// Build option: define C_TRANSPOSE_EN for column-major stream order.

module mult_c_collector #(
    parameter int BITS = 8,
    parameter int N    = 8,
    parameter int WORD = 33
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD-1:0]        c_word,
    input  logic                   c_valid,
    output logic                   c_ready,
    output logic [BITS-1:0]        out_data,
    output logic [$clog2(N)-1:0]   out_row,
    output logic [$clog2(N)-1:0]   out_col,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [N*N*BITS-1:0]    c_matrix,
    output logic                   busy,
    output logic                   done
);

    localparam int HALF = N / 2;
    localparam int RW   = $clog2(N);
    localparam int KW   = $clog2(2 * N);
    localparam int MW   = $clog2(N * N);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_STREAM  = 2'd2
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [MW-1:0]   r_m;
    logic [BITS-1:0] r_mem [N*N];
    logic            r_done;

    logic [BITS-1:0] w_elem_in [HALF];
    logic [RW-1:0]   w_row;
    logic [RW-1:0]   w_col;
    logic [MW-1:0]   w_ridx;
    logic [MW-1:0]   w_wbase;
    logic            w_stream;
    logic            w_last;

    // Split the incoming word into its N/2 elements.
    genvar gi;
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_split
            assign w_elem_in[gi] = c_word[BITS*gi +: BITS];
        end
        for (gi = 0; gi < N*N; gi++) begin : g_flat
            assign c_matrix[BITS*gi +: BITS] = r_mem[gi];
        end
        if (HALF*BITS < WORD) begin : g_pad
            // Bits above the packed elements carry no data.
            logic w_unused_pad;
            assign w_unused_pad = ^c_word[WORD-1:HALF*BITS];
        end
    endgenerate

    // Word k fills row k>>1; odd words fill the right half of that row.
    assign w_wbase = MW'((int'(r_k) >> 1) * N + int'(r_k[0]) * HALF);

`ifdef C_TRANSPOSE_EN
    assign w_col = RW'(int'(r_m) / N);
    assign w_row = RW'(int'(r_m) % N);
`else
    assign w_row = RW'(int'(r_m) / N);
    assign w_col = RW'(int'(r_m) % N);
`endif

    assign w_ridx   = MW'(int'(w_row) * N + int'(w_col));
    assign w_stream = (r_state == S_STREAM);
    assign w_last   = w_stream && (r_m == MW'(N*N - 1));

    assign c_ready   = (r_state == S_COLLECT);
    assign out_valid = w_stream;
    assign out_last  = w_last;
    assign out_data  = w_stream ? r_mem[w_ridx] : '0;
    assign out_row   = w_stream ? w_row : '0;
    assign out_col   = w_stream ? w_col : '0;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_m     <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < N*N; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_COLLECT;
                        r_k     <= '0;
                    end
                end
                S_COLLECT: begin
                    if (c_valid) begin
                        for (int e = 0; e < HALF; e++) begin
                            r_mem[w_wbase + MW'(e)] <= w_elem_in[e];
                        end
                        if (r_k == KW'(2*N - 1)) begin
                            r_state <= S_STREAM;
                            r_k     <= '0;
                            r_m     <= '0;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_m     <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_m <= r_m + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_c_collector.sv
module tb_mult_c_collector;

    localparam int BITS = 8;
    localparam int N    = 8;
    localparam int WORD = 33;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [WORD-1:0]      c_word;
    logic                 c_valid;
    logic                 c_ready;
    logic [BITS-1:0]      out_data;
    logic [2:0]           out_row;
    logic [2:0]           out_col;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [N*N*BITS-1:0]  c_matrix;
    logic                 busy;
    logic                 done;

    mult_c_collector #(.BITS(BITS), .N(N), .WORD(WORD)) dut (
        .clk(clk), .reset(reset), .start(start),
        .c_word(c_word), .c_valid(c_valid), .c_ready(c_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .c_matrix(c_matrix), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] r;
        logic [2:0] c;
        logic       l;
    } item_t;

    item_t q[$];
    int    checks   = 0;
    int    failures = 0;
    int    hs_cnt   = 0;
    bit    bp       = 1'b0;
    int    bp_cnt   = 0;
    bit    exp_done = 1'b0;
    bit    hold     = 1'b0;
    item_t held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_mat(input string name, input logic [N*N*BITS-1:0] exp);
        checks++;
        if (c_matrix !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, c_matrix, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD-1:0] mkword(input int k, input logic [7:0] mask);
        logic [WORD-1:0] w;
        w = '0;
        w[32] = 1'b1;
        for (int e = 0; e < 4; e++) w[8*e +: 8] = 8'(4*k + e) ^ mask;
        return w;
    endfunction

    // C[r][c] = 8r+c (xor mask), i.e. flat element i holds i^mask.
    function automatic logic [N*N*BITS-1:0] exp_mat(input logic [7:0] mask);
        logic [N*N*BITS-1:0] v;
        for (int i = 0; i < N*N; i++) v[8*i +: 8] = 8'(i) ^ mask;
        return v;
    endfunction

    task automatic push_expected(input logic [7:0] mask);
        item_t it;
        int row, col;
        for (int m = 0; m < N*N; m++) begin
`ifdef C_TRANSPOSE_EN
            col = m / N; row = m % N;
`else
            row = m / N; col = m % N;
`endif
            it.d = 8'(8*row + col) ^ mask;
            it.r = 3'(row);
            it.c = 3'(col);
            it.l = (m == N*N - 1);
            q.push_back(it);
        end
    endtask

    task automatic collect(input logic [7:0] mask, input bit stall, input bit start_mid,
                           input logic [7:0] old_c40);
        int k = 0, rdy = 0, guard = 0, stall_cnt = 0;
        logic acc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_collect", {63'd0, busy}, 64'd1);
        hs_cnt = 0;
        while (k < 2*N && guard < 200) begin
            guard++;
            if (stall && k == 8 && stall_cnt < 10) begin
                c_valid = 1'b0;
                stall_cnt++;
                if (stall_cnt == 5) chk("stall_nowrite", {56'd0, c_matrix[8*32 +: 8]}, {56'd0, old_c40});
            end else begin
                c_valid = 1'b1;
                c_word  = mkword(k, mask);
            end
            start = start_mid && (k == 3);
            acc = c_ready && c_valid;
            if (c_ready) rdy++;
            tick();
            if (acc) k++;
        end
        c_valid = 1'b0;
        start   = 1'b0;
        chk("words_accepted", 64'(k), 64'(2*N));
        chk("c_ready_cycles", 64'(rdy), stall ? 64'd26 : 64'd16);
        push_expected(mask);
        chk("c_ready_in_stream", {63'd0, c_ready}, 64'd0);
        chk_mat("matrix_collected", exp_mat(mask));
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 2000) begin
            tick();
            g++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("handshakes", 64'(hs_cnt), 64'd64);
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    // Downstream ready pattern 1,0,0,1 when backpressure is on.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bp_cnt++;
            out_ready = bp ? ((bp_cnt % 4 == 0) || (bp_cnt % 4 == 3)) : 1'b1;
        end
    end

    // Monitor: compares each handshake against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            chk("done_pulse", {63'd0, done}, {63'd0, exp_done});
            exp_done = 1'b0;
            if (hold) chk("hold_stable", 64'({out_data, out_row, out_col, out_last}), 64'(held));
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", out_data);
                end else begin
                    item_t e;
                    e = q.pop_front();
                    chk("beat", 64'({out_data, out_row, out_col, out_last}), 64'(e));
                    exp_done = e.l;
                end
            end
            hold = out_valid && !out_ready;
            held = {out_data, out_row, out_col, out_last};
        end
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        c_valid = 1'b0;
        c_word  = '0;
        tick();
        tick();
        chk("rst_c_ready", {63'd0, c_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_out_fields", 64'({out_data, out_row, out_col}), 64'd0);
        chk_mat("rst_matrix", '0);
        reset = 1'b0;
        tick();

        // Reset in the middle of a collection.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            c_valid = 1'b1;
            c_word  = mkword(k, 8'h00);
            tick();
        end
        c_valid = 1'b0;
        chk("partial_write", {56'd0, c_matrix[8*1 +: 8]}, 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_c_ready", {63'd0, c_ready}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk_mat("midrst_matrix", '0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Full run, ready always high, start pulsed while streaming.
        collect(8'h00, 1'b0, 1'b0, 8'h00);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_stream_busy", {63'd0, busy}, 64'd1);
        chk("start_in_stream_valid", {63'd0, out_valid}, 64'd1);
        wait_done();

        // Start in the done cycle, second pattern, backpressure.
        bp = 1'b1;
        collect(8'hA5, 1'b0, 1'b0, 8'h00);
        wait_done();
        bp = 1'b0;
        repeat (3) tick();
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk_mat("idle_holds_matrix", exp_mat(8'hA5));

        // Stalled input plus start during collection.
        collect(8'h00, 1'b1, 1'b1, 8'h85);
        wait_done();
        tick();
        chk_mat("final_matrix", exp_mat(8'h00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
